itcm_load_master: RTL and testbench
===================================

# itcm_load_master

Instruction-side AHB-Lite read master that services ITCM auto-load. It takes the word-address stream the ITCM presents during auto-load (`itcm_auto_load`, `itcm_auto_load_addr`) and issues pipelined single-word AHB-Lite reads. It returns data to the ITCM through the `IAHB_ready` / `IAHB_read_data` / `IAHB_read_data_valid` handshake. It sits between the ITCM and the instruction AHB fabric (boot flash/ROM slave) and is idle once loading completes.

## Interface
- `LOAD_WORDS`, default `ITCM_SIZE/4`: number of words in one auto-load; legal range 1..2^16.
- `clk`  in  1: clock; all logic on rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `itcm_auto_load`  in  1: ITCM requests loading.
- `itcm_auto_load_addr`  in  32: next word address to fetch; word aligned.
- `IAHB_ready`  out  1: beat accepted this cycle when `itcm_auto_load` is also high.
- `IAHB_read_data`  out  32: returned word.
- `IAHB_read_data_valid`  out  1: `IAHB_read_data` is valid; single-cycle pulse per beat.
- `load_done`  out  1: sticky; all `LOAD_WORDS` beats returned.
- `load_err`  out  1: sticky; an ERROR response was seen and loading was aborted.
- `HADDR`  out  32, `HTRANS`  out  2, `HWRITE`  out  1 (always 0), `HSIZE`  out  3 (always word), `HBURST`  out  3 (always INCR), `HPROT`  out  4 (always 4'b0010): AHB-Lite address phase.
- `HREADY`  in  1, `HRDATA`  in  32, `HRESP`  in  1: AHB-Lite data phase.

## Operation
- Accept condition: `acc = itcm_auto_load & IAHB_ready`.
- `IAHB_ready` is combinational: `~rst & ~load_err & (issued < LOAD_WORDS) & (~dphase | (HREADY & ~HRESP))`.
- `HADDR = itcm_auto_load_addr`.
- `HTRANS`:
  - NONSEQ on the first accepted beat, and on any beat following a cycle without `acc`.
  - SEQ on back-to-back accepted beats.
  - IDLE whenever `acc` is 0.
- `issued` counter (17 bits): increments on `acc`; saturates at `LOAD_WORDS`, and no further beats are issued.
- `dphase` flag: set on `acc`; cleared when `HREADY` is high and no new `acc` occurs. At most one outstanding data phase, per AHB-Lite pipelining.
- Data return: a data phase completes with `HREADY=1` and `HRESP=OKAY`. The block then registers `HRDATA` into `IAHB_read_data` and pulses `IAHB_read_data_valid`.
- `returned` counter: increments on each valid pulse. `load_done` is set on the cycle the pulse for beat `LOAD_WORDS` is driven.
- Error response:
  - First ERROR cycle (`HRESP=1`, `HREADY=0`): `IAHB_ready` drops and `HTRANS` is driven IDLE.
  - Second cycle (`HRESP=1`, `HREADY=1`): `load_err` is set and no valid pulse is produced for that beat.
  - No further beats are issued until reset.
- `itcm_auto_load` falling mid-load: no new beats are issued. A pending data phase still completes and delivers its valid pulse. Counters hold.
- `itcm_auto_load` rising again later resumes issuing from the current `issued` value.

## Timing
- Reset values: `IAHB_read_data_valid`=0, `IAHB_read_data`=0, `load_done`=0, `load_err`=0, `HTRANS`=IDLE, `IAHB_ready`=0 while `rst` is high; all counters 0, `dphase`=0.
- Latency: beat accepted in cycle k (address phase) → data phase in cycle k+1 → with zero wait states, `IAHB_read_data_valid` is high in cycle k+2.
- Each wait state (`HREADY`=0) adds one cycle and stalls `IAHB_ready`.
- Throughput: 1 word/cycle with zero wait states; `LOAD_WORDS` words complete in `LOAD_WORDS`+2 cycles from the first accept.
- Data returns in order, exactly one valid pulse per accepted, non-errored beat.
- Reset mid-operation: everything clears immediately. The pending data phase is dropped and `HTRANS` returns to IDLE asynchronously.

## Structure
- Shared defines header (alongside `core_defines.vh`): HTRANS encodings (IDLE/NONSEQ/SEQ), `HSIZE_WORD`, `HBURST_INCR`, `HRESP_OKAY`/`HRESP_ERROR`.
- Single module, no sub-modules. All logic is the two counters, the `dphase` flag, the NONSEQ/SEQ tracking flag, the error sequencer and the read-data register.

## Test plan
- Zero-wait load, `LOAD_WORDS`=4, slave returns addr+0x100:
  - expect `HTRANS` NONSEQ,SEQ,SEQ,SEQ,IDLE;
  - 4 valid pulses in cycles 3..6 carrying 0x100,0x104,0x108,0x10C;
  - `load_done` set in cycle 6.
- Slave inserts 2 wait states on beat 2: `IAHB_ready` low for 2 cycles, `HADDR` held, beat 2 data delayed 2 cycles, total 8 cycles.
- ERROR response on beat 3 of 8:
  - `HTRANS`=IDLE in the first error cycle;
  - `load_err`=1 after the second;
  - exactly 2 valid pulses, `load_done` stays 0, no further `acc`.
- `itcm_auto_load` dropped after beat 2 accepted, re-raised 5 cycles later: beat 2 still delivered; next beat is NONSEQ; total beats = `LOAD_WORDS`.
- `rst` asserted during the data phase of beat 3: outputs return to reset values in the same cycle. After release, a full reload completes normally.
- `itcm_auto_load` held high after `load_done`: `IAHB_ready` stays 0 and `HTRANS` stays IDLE indefinitely.

Source files
------------

// File: rtl/itcm_load_master_pkg.sv
// Shared AHB-Lite encodings and ITCM sizing used by the ITCM auto-load master.
package itcm_load_master_pkg;

  localparam int ITCM_SIZE = 65536;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [3:0] HPROT_DEFAULT = 4'b0010;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;

endpackage

// File: rtl/itcm_load_master.sv
// AHB-Lite read master that streams ITCM auto-load words from the instruction
// fabric, one outstanding data phase at a time, with in-order data return.
module itcm_load_master
  import itcm_load_master_pkg::*;
#(
  parameter int LOAD_WORDS = ITCM_SIZE / 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        itcm_auto_load,
  input  logic [31:0] itcm_auto_load_addr,
  output logic        IAHB_ready,
  output logic [31:0] IAHB_read_data,
  output logic        IAHB_read_data_valid,
  output logic        load_done,
  output logic        load_err,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  input  logic        HREADY,
  input  logic [31:0] HRDATA,
  input  logic        HRESP
);

  localparam logic [16:0] LOAD_LIMIT = 17'(LOAD_WORDS);

  logic [16:0] issued;
  logic [16:0] returned;
  logic        dphase;
  logic        prev_acc;
  logic        acc;
  logic        beat_ok;
  logic        beat_err;

  assign beat_ok  = dphase & HREADY & (HRESP == HRESP_OKAY);
  assign beat_err = dphase & HREADY & (HRESP == HRESP_ERROR);

  // A new address phase may only overlap a data phase that is finishing cleanly,
  // so the first ERROR cycle (HREADY low) already blocks further issue.
  assign IAHB_ready = ~rst & ~load_err & (issued < LOAD_LIMIT) &
                      (~dphase | (HREADY & (HRESP == HRESP_OKAY)));
  assign acc        = itcm_auto_load & IAHB_ready;

  assign HADDR  = itcm_auto_load_addr;
  assign HTRANS = acc ? (prev_acc ? HTRANS_SEQ : HTRANS_NONSEQ) : HTRANS_IDLE;
  assign HWRITE = 1'b0;
  assign HSIZE  = HSIZE_WORD;
  assign HBURST = HBURST_INCR;
  assign HPROT  = HPROT_DEFAULT;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued   <= '0;
      dphase   <= 1'b0;
      prev_acc <= 1'b0;
    end else begin
      prev_acc <= acc;
      dphase   <= acc | (dphase & ~HREADY);
      if (acc) begin
        issued <= issued + 17'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      returned             <= '0;
      IAHB_read_data       <= '0;
      IAHB_read_data_valid <= 1'b0;
      load_done            <= 1'b0;
      load_err             <= 1'b0;
    end else begin
      IAHB_read_data_valid <= beat_ok;
      if (beat_ok) begin
        IAHB_read_data <= HRDATA;
        returned       <= returned + 17'd1;
        if (returned + 17'd1 == LOAD_LIMIT) begin
          load_done <= 1'b1;
        end
      end
      if (beat_err) begin
        load_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_itcm_load_master.sv
// Directed bench for itcm_load_master with a small AHB-Lite slave (data = addr+0x100)
// and an ITCM address source that advances on each accepted beat.
module tb_itcm_load_master;

  logic        clk;
  logic        rst;
  logic        itcm_auto_load;
  logic [31:0] itcm_auto_load_addr;
  logic        IAHB_ready;
  logic [31:0] IAHB_read_data;
  logic        IAHB_read_data_valid;
  logic        load_done;
  logic        load_err;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HRESP;

  itcm_load_master #(.LOAD_WORDS(4)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .itcm_auto_load       (itcm_auto_load),
    .itcm_auto_load_addr  (itcm_auto_load_addr),
    .IAHB_ready           (IAHB_ready),
    .IAHB_read_data       (IAHB_read_data),
    .IAHB_read_data_valid (IAHB_read_data_valid),
    .load_done            (load_done),
    .load_err             (load_err),
    .HADDR                (HADDR),
    .HTRANS               (HTRANS),
    .HWRITE               (HWRITE),
    .HSIZE                (HSIZE),
    .HBURST               (HBURST),
    .HPROT                (HPROT),
    .HREADY               (HREADY),
    .HRDATA               (HRDATA),
    .HRESP                (HRESP)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] addr_idx;
  assign itcm_auto_load_addr = {addr_idx[29:0], 2'b00};

  always @(posedge clk or posedge rst) begin
    if (rst) addr_idx <= '0;
    else if (itcm_auto_load && IAHB_ready) addr_idx <= addr_idx + 32'd1;
  end

  // Slave: optional wait states on one beat, optional two-cycle ERROR on another.
  int          wait_beat = 0;
  int          wait_len  = 0;
  int          err_beat  = 0;
  logic        s_active;
  logic        s_err;
  logic [31:0] s_addr;
  int          s_beat;
  int          s_wait;
  int          s_errph;

  always_comb begin
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = '0;
    if (s_active) begin
      if (s_err) begin
        HRESP  = 1'b1;
        HREADY = (s_errph == 2);
      end else if (s_wait > 0) begin
        HREADY = 1'b0;
      end else begin
        HRDATA = s_addr + 32'h100;
      end
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_active <= 1'b0; s_err <= 1'b0; s_addr <= '0;
      s_beat <= 0; s_wait <= 0; s_errph <= 0;
    end else if (!HREADY) begin
      if (s_err) s_errph <= 2;
      else       s_wait  <= s_wait - 1;
    end else if (HTRANS[1]) begin
      s_active <= 1'b1;
      s_addr   <= HADDR;
      s_beat   <= s_beat + 1;
      s_wait   <= (s_beat + 1 == wait_beat) ? wait_len : 0;
      s_err    <= (s_beat + 1 == err_beat);
      s_errph  <= 1;
    end else begin
      s_active <= 1'b0;
      s_err    <= 1'b0;
    end
  end

  logic [1:0]  lg_htrans [40];
  logic        lg_ready  [40];
  logic        lg_valid  [40];
  logic [31:0] lg_data   [40];
  logic        lg_done   [40];
  logic        lg_err    [40];
  logic [31:0] lg_haddr  [40];
  int          n_valid;
  int          n_acc;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  task automatic resetDut(input bit check_reset);
    rst            = 1'b1;
    itcm_auto_load = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    if (check_reset) begin
      checkOutput("rst_valid",  {31'd0, IAHB_read_data_valid}, 32'd0);
      checkOutput("rst_data",   IAHB_read_data, 32'd0);
      checkOutput("rst_done",   {31'd0, load_done}, 32'd0);
      checkOutput("rst_err",    {31'd0, load_err}, 32'd0);
      checkOutput("rst_htrans", {30'd0, HTRANS}, 32'd0);
      checkOutput("rst_ready",  {31'd0, IAHB_ready}, 32'd0);
      checkOutput("hsize",      {29'd0, HSIZE}, 32'd2);
      checkOutput("hburst",     {29'd0, HBURST}, 32'd1);
      checkOutput("hprot",      {28'd0, HPROT}, 32'd2);
      checkOutput("hwrite",     {31'd0, HWRITE}, 32'd0);
    end
    @(posedge clk);
    #1;
    rst            = 1'b0;
    itcm_auto_load = 1'b0;
  endtask

  // Cycle c spans from just after posedge c-1 to posedge c; outputs logged mid-cycle.
  task automatic applyStimulus(input logic [39:0] pat, input int n);
    n_valid = 0;
    n_acc   = 0;
    for (int c = 1; c <= n; c++) begin
      itcm_auto_load = pat[c-1];
      @(negedge clk);
      lg_htrans[c] = HTRANS;
      lg_ready[c]  = IAHB_ready;
      lg_valid[c]  = IAHB_read_data_valid;
      lg_data[c]   = IAHB_read_data;
      lg_done[c]   = load_done;
      lg_err[c]    = load_err;
      lg_haddr[c]  = HADDR;
      if (IAHB_read_data_valid) n_valid++;
      if (itcm_auto_load && IAHB_ready) n_acc++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst            = 1'b1;
    itcm_auto_load = 1'b0;

    $display("[TB] zero-wait load");
    resetDut(1'b1);
    applyStimulus(40'hFF_FFFF_FFFF, 12);
    checkOutput("t1_htrans1", {30'd0, lg_htrans[1]}, 32'd2);
    checkOutput("t1_htrans2", {30'd0, lg_htrans[2]}, 32'd3);
    checkOutput("t1_htrans3", {30'd0, lg_htrans[3]}, 32'd3);
    checkOutput("t1_htrans4", {30'd0, lg_htrans[4]}, 32'd3);
    checkOutput("t1_htrans5", {30'd0, lg_htrans[5]}, 32'd0);
    checkOutput("t1_valid2",  {31'd0, lg_valid[2]}, 32'd0);
    for (int c = 3; c <= 6; c++) begin
      checkOutput($sformatf("t1_valid%0d", c), {31'd0, lg_valid[c]}, 32'd1);
      checkOutput($sformatf("t1_data%0d", c), lg_data[c], 32'h100 + 32'(4 * (c - 3)));
    end
    checkOutput("t1_nvalid", n_valid, 32'd4);
    checkOutput("t1_done5",  {31'd0, lg_done[5]}, 32'd0);
    checkOutput("t1_done6",  {31'd0, lg_done[6]}, 32'd1);
    for (int c = 7; c <= 12; c++) begin
      checkOutput($sformatf("t6_ready%0d", c), {31'd0, lg_ready[c]}, 32'd0);
      checkOutput($sformatf("t6_htrans%0d", c), {30'd0, lg_htrans[c]}, 32'd0);
    end

    $display("[TB] two wait states on beat 2");
    wait_beat = 2;
    wait_len  = 2;
    resetDut(1'b0);
    applyStimulus(40'hFF_FFFF_FFFF, 10);
    checkOutput("t2_ready3",  {31'd0, lg_ready[3]}, 32'd0);
    checkOutput("t2_ready4",  {31'd0, lg_ready[4]}, 32'd0);
    checkOutput("t2_ready5",  {31'd0, lg_ready[5]}, 32'd1);
    checkOutput("t2_haddr3",  lg_haddr[3], 32'h8);
    checkOutput("t2_haddr5",  lg_haddr[5], 32'h8);
    checkOutput("t2_htrans5", {30'd0, lg_htrans[5]}, 32'd2);
    checkOutput("t2_valid4",  {31'd0, lg_valid[4]}, 32'd0);
    checkOutput("t2_data6",   lg_data[6], 32'h104);
    checkOutput("t2_data8",   lg_data[8], 32'h10C);
    checkOutput("t2_done7",   {31'd0, lg_done[7]}, 32'd0);
    checkOutput("t2_done8",   {31'd0, lg_done[8]}, 32'd1);
    checkOutput("t2_nvalid",  n_valid, 32'd4);
    wait_beat = 0;
    wait_len  = 0;

    $display("[TB] error response on beat 3");
    err_beat = 3;
    resetDut(1'b0);
    applyStimulus(40'hFF_FFFF_FFFF, 12);
    checkOutput("t3_htrans4", {30'd0, lg_htrans[4]}, 32'd0);
    checkOutput("t3_ready4",  {31'd0, lg_ready[4]}, 32'd0);
    checkOutput("t3_err5",    {31'd0, lg_err[5]}, 32'd0);
    checkOutput("t3_err6",    {31'd0, lg_err[6]}, 32'd1);
    checkOutput("t3_nvalid",  n_valid, 32'd2);
    checkOutput("t3_nacc",    n_acc, 32'd3);
    checkOutput("t3_done12",  {31'd0, lg_done[12]}, 32'd0);
    checkOutput("t3_ready12", {31'd0, lg_ready[12]}, 32'd0);
    err_beat = 0;

    $display("[TB] auto_load dropped and re-raised");
    resetDut(1'b0);
    applyStimulus(40'h00_0000_3F83, 14);
    checkOutput("t4_htrans3", {30'd0, lg_htrans[3]}, 32'd0);
    checkOutput("t4_data4",   lg_data[4], 32'h104);
    checkOutput("t4_valid4",  {31'd0, lg_valid[4]}, 32'd1);
    checkOutput("t4_htrans8", {30'd0, lg_htrans[8]}, 32'd2);
    checkOutput("t4_haddr8",  lg_haddr[8], 32'h8);
    checkOutput("t4_htrans9", {30'd0, lg_htrans[9]}, 32'd3);
    checkOutput("t4_htrans10", {30'd0, lg_htrans[10]}, 32'd0);
    checkOutput("t4_done11",  {31'd0, lg_done[11]}, 32'd1);
    checkOutput("t4_nvalid",  n_valid, 32'd4);
    checkOutput("t4_nacc",    n_acc, 32'd4);

    $display("[TB] reset during data phase of beat 3");
    resetDut(1'b0);
    applyStimulus(40'hFF_FFFF_FFFF, 3);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t5_valid",  {31'd0, IAHB_read_data_valid}, 32'd0);
    checkOutput("t5_data",   IAHB_read_data, 32'd0);
    checkOutput("t5_htrans", {30'd0, HTRANS}, 32'd0);
    checkOutput("t5_ready",  {31'd0, IAHB_ready}, 32'd0);
    resetDut(1'b0);
    applyStimulus(40'hFF_FFFF_FFFF, 8);
    checkOutput("t5_data3",  lg_data[3], 32'h100);
    checkOutput("t5_data6",  lg_data[6], 32'h10C);
    checkOutput("t5_done6",  {31'd0, lg_done[6]}, 32'd1);
    checkOutput("t5_nvalid", n_valid, 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
